// File: rtl/cavlc_block_sequencer_if.sv
// Handshake and data bundle between the CAVLC sub-decoders / bitstream buffer
// and the block sequencer. The sequencer uses the slave view; the surrounding
// datapath (or a testbench) uses the master view.
interface cavlc_block_sequencer_if;
  logic       start;
  logic [4:0] max_num_coeff;
  logic       bits_ready;
  logic [4:0] coeff_token_len;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;
  logic [4:0] level_len;
  logic [3:0] total_zeros;
  logic [3:0] total_zeros_len;
  logic [3:0] run_before;
  logic [3:0] run_before_len;
  logic [3:0] cavlc_decoder_state;
  logic       consume_valid;
  logic [4:0] consume_len;
  logic [4:0] coeff_idx;
  logic [3:0] zeros_left;
  logic       busy;
  logic       done;
  logic       run_error;

  modport slave (
    input  start, max_num_coeff, bits_ready, coeff_token_len, total_coeff,
           trailing_ones, level_len, total_zeros, total_zeros_len,
           run_before, run_before_len,
    output cavlc_decoder_state, consume_valid, consume_len, coeff_idx,
           zeros_left, busy, done, run_error
  );

  modport master (
    output start, max_num_coeff, bits_ready, coeff_token_len, total_coeff,
           trailing_ones, level_len, total_zeros, total_zeros_len,
           run_before, run_before_len,
    input  cavlc_decoder_state, consume_valid, consume_len, coeff_idx,
           zeros_left, busy, done, run_error
  );
endinterface

// File: rtl/cavlc_block_sequencer.sv
// CAVLC residual block sequencer: walks one block through coeff_token,
// trailing-one signs, levels, total_zeros and run_before, telling the
// bitstream buffer how many bits to advance after each syntax element.
module cavlc_block_sequencer (
  input  logic                          clk,
  input  logic                          reset_n,
  cavlc_block_sequencer_if.slave        bus
);

  typedef enum logic [3:0] {
    IDLE            = 4'd0,
    COEFF_TOKEN     = 4'd1,
    TRAILING_ONES   = 4'd2,
    LEVEL           = 4'd3,
    TOTAL_ZEROS_LUT = 4'd4,
    RUN_BEFORE      = 4'd5,
    DONE            = 4'd6
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] maxCoeff_q, maxCoeff_d;
  logic [4:0] totalCoeff_q, totalCoeff_d;
  logic [1:0] trailingOnes_q, trailingOnes_d;
  logic [4:0] coeffIdx_q, coeffIdx_d;
  logic [3:0] zerosLeft_q, zerosLeft_d;
  logic       runError_q, runError_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       consumeValid;
  logic [4:0] consumeLen;
  logic       zerosCheck;
  logic [3:0] runZerosNext;
  logic [4:0] coeffIdxInc;
  logic [4:0] totalCoeffDec;

  assign coeffIdxInc   = coeffIdx_q + 5'd1;
  assign totalCoeffDec = totalCoeff_q - 5'd1;

  // Next-state decode plus the unregistered consume strobe/length; the shared
  // "zeros check" is flagged inside the case and resolved once at the end.
  always_comb begin
    state_d        = state_q;
    maxCoeff_d     = maxCoeff_q;
    totalCoeff_d   = totalCoeff_q;
    trailingOnes_d = trailingOnes_q;
    coeffIdx_d     = coeffIdx_q;
    zerosLeft_d    = zerosLeft_q;
    runError_d     = runError_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    consumeValid   = 1'b0;
    consumeLen     = 5'd0;
    zerosCheck     = 1'b0;
    runZerosNext   = 4'd0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          maxCoeff_d  = bus.max_num_coeff;
          runError_d  = 1'b0;
          coeffIdx_d  = 5'd0;
          zerosLeft_d = 4'd0;
          busy_d      = 1'b1;
          state_d     = COEFF_TOKEN;
        end
      end
      COEFF_TOKEN: begin
        if (bus.bits_ready) begin
          consumeValid   = 1'b1;
          consumeLen     = bus.coeff_token_len;
          totalCoeff_d   = bus.total_coeff;
          trailingOnes_d = bus.trailing_ones;
          if (bus.total_coeff == 5'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (bus.trailing_ones != 2'd0) begin
            state_d = TRAILING_ONES;
          end else begin
            state_d = LEVEL;
          end
        end
      end
      TRAILING_ONES: begin
        if (bus.bits_ready) begin
          consumeValid = 1'b1;
          consumeLen   = {3'b000, trailingOnes_q};
          coeffIdx_d   = coeffIdx_q + {3'b000, trailingOnes_q};
          if (totalCoeff_q == {3'b000, trailingOnes_q}) begin
            zerosCheck = 1'b1;
          end else begin
            state_d = LEVEL;
          end
        end
      end
      LEVEL: begin
        if (bus.bits_ready) begin
          consumeValid = 1'b1;
          consumeLen   = bus.level_len;
          coeffIdx_d   = coeffIdxInc;
          if (coeffIdxInc >= totalCoeff_q) begin
            zerosCheck = 1'b1;
          end
        end
      end
      TOTAL_ZEROS_LUT: begin
        if (bus.bits_ready) begin
          consumeValid = 1'b1;
          consumeLen   = {1'b0, bus.total_zeros_len};
          zerosLeft_d  = bus.total_zeros;
          coeffIdx_d   = 5'd0;
          if ((bus.total_zeros == 4'd0) || (totalCoeff_q == 5'd1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN_BEFORE;
          end
        end
      end
      RUN_BEFORE: begin
        if (bus.bits_ready) begin
          consumeValid = 1'b1;
          consumeLen   = {1'b0, bus.run_before_len};
          coeffIdx_d   = coeffIdxInc;
          if (bus.run_before > zerosLeft_q) begin
            runZerosNext = 4'd0;
            runError_d   = 1'b1;
          end else begin
            runZerosNext = zerosLeft_q - bus.run_before;
          end
          zerosLeft_d = runZerosNext;
          if ((runZerosNext == 4'd0) || (coeffIdxInc == totalCoeffDec)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (zerosCheck) begin
      if (totalCoeff_q < maxCoeff_q) begin
        state_d = TOTAL_ZEROS_LUT;
      end else begin
        zerosLeft_d = 4'd0;
        state_d     = DONE;
        done_d      = 1'b1;
      end
    end
  end

  // Register every piece of sequencer state; reset wins over any start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      maxCoeff_q     <= 5'd0;
      totalCoeff_q   <= 5'd0;
      trailingOnes_q <= 2'd0;
      coeffIdx_q     <= 5'd0;
      zerosLeft_q    <= 4'd0;
      runError_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      maxCoeff_q     <= maxCoeff_d;
      totalCoeff_q   <= totalCoeff_d;
      trailingOnes_q <= trailingOnes_d;
      coeffIdx_q     <= coeffIdx_d;
      zerosLeft_q    <= zerosLeft_d;
      runError_q     <= runError_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.cavlc_decoder_state = state_q;
  assign bus.consume_valid       = consumeValid;
  assign bus.consume_len         = consumeLen;
  assign bus.coeff_idx           = coeffIdx_q;
  assign bus.zeros_left          = zerosLeft_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.run_error           = runError_q;

endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// Directed testbench for the CAVLC block sequencer: each task drives one
// scenario and compares outputs against hand-computed values.
module tb_cavlc_block_sequencer;

  logic clk;
  logic reset_n;
  cavlc_block_sequencer_if bus();

  cavlc_block_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int consLog[$];
  int stLog[$];
  int zlLog[$];
  int runVals[$];
  int runIdx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each consume (length and state) and zeros_left while in RUN_BEFORE.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.consume_valid === 1'b1) begin
      consLog.push_back(int'(bus.consume_len));
      stLog.push_back(int'(bus.cavlc_decoder_state));
      if (bus.cavlc_decoder_state == 4'd5) runIdx++;
    end
    if (reset_n === 1'b1 && bus.cavlc_decoder_state == 4'd5)
      zlLog.push_back(int'(bus.zeros_left));
  end

  function automatic string q2s(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = (i == 0) ? $sformatf("%0d", q[i]) : $sformatf("%s %0d", s, q[i]);
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
    bus.run_before = (runIdx < runVals.size()) ? 4'(runVals[runIdx]) : 4'd0;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic runBlock(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      cyc();
      if (bus.done === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic setDefaults();
    cyc();
    cyc();
    bus.start           = 1'b0;
    bus.max_num_coeff   = 5'd16;
    bus.bits_ready      = 1'b1;
    bus.coeff_token_len = 5'd1;
    bus.total_coeff     = 5'd0;
    bus.trailing_ones   = 2'd0;
    bus.level_len       = 5'd1;
    bus.total_zeros     = 4'd0;
    bus.total_zeros_len = 4'd1;
    bus.run_before      = 4'd0;
    bus.run_before_len  = 4'd1;
    consLog.delete();
    stLog.delete();
    zlLog.delete();
    runVals.delete();
    runIdx = 0;
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    setDefaults();
    bus.start = 1'b1;
    cyc();
    #1;
    obs = {bus.cavlc_decoder_state, bus.busy, bus.done, bus.run_error, bus.coeff_idx,
           bus.zeros_left, bus.consume_valid, bus.consume_len};
    vectors++;
    if (obs !== 22'd0) begin miscompares++; $display("[TB] FAIL reset_outputs: got %h, expected 0", obs); end
    reset_n = 1'b1;
    bus.start = 1'b0;
    cyc();
    vectors++;
    if ({bus.cavlc_decoder_state, bus.busy} !== 5'd0) begin miscompares++;
      $display("[TB] FAIL reset_start_discarded: got state %0d busy %0d, expected 0 0", bus.cavlc_decoder_state, bus.busy); end
  endtask

  task automatic test_empty_block();
    setDefaults();
    bus.total_coeff = 5'd0;
    bus.coeff_token_len = 5'd1;
    pulseStart();
    #1;
    vectors++;
    if ({bus.cavlc_decoder_state, bus.busy, bus.consume_valid, bus.consume_len} !== {4'd1, 1'b1, 1'b1, 5'd1}) begin miscompares++;
      $display("[TB] FAIL empty_token: got state %0d busy %0d cv %0d len %0d, expected 1 1 1 1",
               bus.cavlc_decoder_state, bus.busy, bus.consume_valid, bus.consume_len); end
    cyc();
    #1;
    vectors++;
    if ({bus.cavlc_decoder_state, bus.done, bus.busy, bus.consume_valid, bus.consume_len} !== {4'd6, 1'b1, 1'b1, 1'b0, 5'd0}) begin miscompares++;
      $display("[TB] FAIL empty_done: got state %0d done %0d busy %0d cv %0d len %0d, expected 6 1 1 0 0",
               bus.cavlc_decoder_state, bus.done, bus.busy, bus.consume_valid, bus.consume_len); end
    cyc();
    vectors++;
    if ({bus.cavlc_decoder_state, bus.done, bus.busy} !== {4'd0, 1'b0, 1'b0}) begin miscompares++;
      $display("[TB] FAIL empty_idle: got state %0d done %0d busy %0d, expected 0 0 0", bus.cavlc_decoder_state, bus.done, bus.busy); end
    vectors++;
    if (q2s(consLog) != "1") begin miscompares++; $display("[TB] FAIL empty_consumes: got '%s', expected '1'", q2s(consLog)); end
  endtask

  task automatic test_full_path();
    int cycles;
    setDefaults();
    bus.total_coeff = 5'd3; bus.trailing_ones = 2'd1; bus.coeff_token_len = 5'd7;
    bus.level_len = 5'd3; bus.total_zeros = 4'd4; bus.total_zeros_len = 4'd5; bus.run_before_len = 4'd2;
    runVals.push_back(1); runVals.push_back(3);
    pulseStart();
    runBlock(40, cycles);
    vectors++;
    if (cycles !== 7) begin miscompares++; $display("[TB] FAIL full_cycles: got %0d, expected 7", cycles); end
    vectors++;
    if (q2s(consLog) != "7 1 3 3 5 2 2") begin miscompares++; $display("[TB] FAIL full_consumes: got '%s', expected '7 1 3 3 5 2 2'", q2s(consLog)); end
    vectors++;
    if (q2s(stLog) != "1 2 3 3 4 5 5") begin miscompares++; $display("[TB] FAIL full_states: got '%s', expected '1 2 3 3 4 5 5'", q2s(stLog)); end
    vectors++;
    if (q2s(zlLog) != "4 3") begin miscompares++; $display("[TB] FAIL full_zeros_trace: got '%s', expected '4 3'", q2s(zlLog)); end
    vectors++;
    if ({bus.zeros_left, bus.coeff_idx, bus.run_error} !== {4'd0, 5'd2, 1'b0}) begin miscompares++;
      $display("[TB] FAIL full_final: got zl %0d idx %0d err %0d, expected 0 2 0", bus.zeros_left, bus.coeff_idx, bus.run_error); end
  endtask

  task automatic test_max_coeffs();
    int cycles;
    string expC, expS;
    setDefaults();
    bus.total_coeff = 5'd16; bus.trailing_ones = 2'd3; bus.coeff_token_len = 5'd10; bus.level_len = 5'd4;
    expC = "10 3";
    expS = "1 2";
    for (int i = 0; i < 13; i++) begin expC = {expC, " 4"}; expS = {expS, " 3"}; end
    pulseStart();
    runBlock(40, cycles);
    vectors++;
    if (cycles !== 15) begin miscompares++; $display("[TB] FAIL max_cycles: got %0d, expected 15", cycles); end
    vectors++;
    if (q2s(consLog) != expC) begin miscompares++; $display("[TB] FAIL max_consumes: got '%s', expected '%s'", q2s(consLog), expC); end
    vectors++;
    if (q2s(stLog) != expS) begin miscompares++; $display("[TB] FAIL max_states: got '%s', expected '%s'", q2s(stLog), expS); end
    vectors++;
    if ({bus.zeros_left, bus.coeff_idx} !== {4'd0, 5'd16}) begin miscompares++;
      $display("[TB] FAIL max_final: got zl %0d idx %0d, expected 0 16", bus.zeros_left, bus.coeff_idx); end
  endtask

  task automatic test_single_coeff();
    int cycles;
    setDefaults();
    bus.max_num_coeff = 5'd4; bus.total_coeff = 5'd1; bus.trailing_ones = 2'd1; bus.coeff_token_len = 5'd2;
    bus.total_zeros = 4'd3; bus.total_zeros_len = 4'd3;
    pulseStart();
    runBlock(40, cycles);
    vectors++;
    if (cycles !== 3) begin miscompares++; $display("[TB] FAIL single_cycles: got %0d, expected 3", cycles); end
    vectors++;
    if (q2s(consLog) != "2 1 3") begin miscompares++; $display("[TB] FAIL single_consumes: got '%s', expected '2 1 3'", q2s(consLog)); end
    vectors++;
    if ({bus.zeros_left, bus.coeff_idx} !== {4'd3, 5'd0}) begin miscompares++;
      $display("[TB] FAIL single_final: got zl %0d idx %0d, expected 3 0", bus.zeros_left, bus.coeff_idx); end
  endtask

  task automatic test_run_exit_by_count();
    int cycles;
    setDefaults();
    bus.total_coeff = 5'd3; bus.trailing_ones = 2'd3; bus.coeff_token_len = 5'd5;
    bus.total_zeros = 4'd5; bus.total_zeros_len = 4'd4; bus.run_before_len = 4'd3;
    runVals.push_back(1); runVals.push_back(1);
    pulseStart();
    runBlock(40, cycles);
    vectors++;
    if (cycles !== 5) begin miscompares++; $display("[TB] FAIL count_cycles: got %0d, expected 5", cycles); end
    vectors++;
    if (q2s(consLog) != "5 3 4 3 3") begin miscompares++; $display("[TB] FAIL count_consumes: got '%s', expected '5 3 4 3 3'", q2s(consLog)); end
    vectors++;
    if ({bus.zeros_left, bus.coeff_idx, bus.run_error} !== {4'd3, 5'd2, 1'b0}) begin miscompares++;
      $display("[TB] FAIL count_final: got zl %0d idx %0d err %0d, expected 3 2 0", bus.zeros_left, bus.coeff_idx, bus.run_error); end
  endtask

  task automatic test_stall();
    int cycles;
    setDefaults();
    bus.total_coeff = 5'd4; bus.trailing_ones = 2'd0; bus.coeff_token_len = 5'd3;
    bus.level_len = 5'd5; bus.total_zeros = 4'd0; bus.total_zeros_len = 4'd2;
    pulseStart();
    cyc();
    cyc();
    bus.bits_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      vectors++;
      if ({bus.cavlc_decoder_state, bus.coeff_idx} !== {4'd3, 5'd1}) begin miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: got state %0d idx %0d, expected 3 1", i, bus.cavlc_decoder_state, bus.coeff_idx); end
      vectors++;
      if ({bus.consume_valid, bus.consume_len} !== 6'd0) begin miscompares++;
        $display("[TB] FAIL stall_consume[%0d]: got cv %0d len %0d, expected 0 0", i, bus.consume_valid, bus.consume_len); end
    end
    bus.bits_ready = 1'b1;
    runBlock(40, cycles);
    vectors++;
    if (cycles !== 4) begin miscompares++; $display("[TB] FAIL stall_cycles: got %0d, expected 4", cycles); end
    vectors++;
    if (q2s(consLog) != "3 5 5 5 5 2") begin miscompares++; $display("[TB] FAIL stall_consumes: got '%s', expected '3 5 5 5 5 2'", q2s(consLog)); end
  endtask

  task automatic test_run_error();
    int cycles;
    setDefaults();
    bus.total_coeff = 5'd2; bus.trailing_ones = 2'd2; bus.coeff_token_len = 5'd4;
    bus.total_zeros = 4'd2; bus.total_zeros_len = 4'd3; bus.run_before_len = 4'd2;
    runVals.push_back(3);
    pulseStart();
    runBlock(40, cycles);
    vectors++;
    if (cycles !== 4) begin miscompares++; $display("[TB] FAIL err_cycles: got %0d, expected 4", cycles); end
    vectors++;
    if (q2s(stLog) != "1 2 4 5") begin miscompares++; $display("[TB] FAIL err_states: got '%s', expected '1 2 4 5'", q2s(stLog)); end
    vectors++;
    if ({bus.cavlc_decoder_state, bus.run_error, bus.zeros_left} !== {4'd6, 1'b1, 4'd0}) begin miscompares++;
      $display("[TB] FAIL err_flag: got state %0d err %0d zl %0d, expected 6 1 0", bus.cavlc_decoder_state, bus.run_error, bus.zeros_left); end
    cyc();
    vectors++;
    if ({bus.cavlc_decoder_state, bus.run_error} !== {4'd0, 1'b1}) begin miscompares++;
      $display("[TB] FAIL err_sticky: got state %0d err %0d, expected 0 1", bus.cavlc_decoder_state, bus.run_error); end
    bus.total_coeff = 5'd0;
    pulseStart();
    vectors++;
    if ({bus.cavlc_decoder_state, bus.run_error} !== {4'd1, 1'b0}) begin miscompares++;
      $display("[TB] FAIL err_cleared: got state %0d err %0d, expected 1 0", bus.cavlc_decoder_state, bus.run_error); end
    runBlock(10, cycles);
  endtask

  task automatic test_busy_start_ignored();
    int cycles;
    setDefaults();
    bus.total_coeff = 5'd4; bus.trailing_ones = 2'd0; bus.coeff_token_len = 5'd3;
    bus.level_len = 5'd2; bus.total_zeros = 4'd0; bus.total_zeros_len = 4'd1;
    pulseStart();
    cyc();
    bus.start = 1'b1;
    bus.max_num_coeff = 5'd4;
    cyc();
    cyc();
    bus.start = 1'b0;
    bus.max_num_coeff = 5'd16;
    runBlock(40, cycles);
    vectors++;
    if (q2s(consLog) != "3 2 2 2 2 1") begin miscompares++; $display("[TB] FAIL busy_consumes: got '%s', expected '3 2 2 2 2 1'", q2s(consLog)); end
    vectors++;
    if (q2s(stLog) != "1 3 3 3 3 4") begin miscompares++; $display("[TB] FAIL busy_states: got '%s', expected '1 3 3 3 3 4'", q2s(stLog)); end
  endtask

  task automatic test_reset_mid_block();
    int cycles;
    int reached;
    logic [21:0] obs;
    setDefaults();
    bus.total_coeff = 5'd3; bus.trailing_ones = 2'd3; bus.coeff_token_len = 5'd5;
    bus.total_zeros = 4'd5; bus.total_zeros_len = 4'd4; bus.run_before_len = 4'd3;
    runVals.push_back(1); runVals.push_back(1);
    pulseStart();
    reached = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus.cavlc_decoder_state == 4'd5) begin reached = c; break; end
      cyc();
    end
    vectors++;
    if (reached !== 4) begin miscompares++; $display("[TB] FAIL midrst_reach_run: got %0d, expected 4", reached); end
    reset_n = 1'b0;
    cyc();
    #1;
    obs = {bus.cavlc_decoder_state, bus.busy, bus.done, bus.run_error, bus.coeff_idx,
           bus.zeros_left, bus.consume_valid, bus.consume_len};
    vectors++;
    if (obs !== 22'd0) begin miscompares++; $display("[TB] FAIL midrst_outputs: got %h, expected 0", obs); end
    reset_n = 1'b1;
    setDefaults();
    bus.total_coeff = 5'd3; bus.trailing_ones = 2'd1; bus.coeff_token_len = 5'd7;
    bus.level_len = 5'd3; bus.total_zeros = 4'd4; bus.total_zeros_len = 4'd5; bus.run_before_len = 4'd2;
    runVals.push_back(1); runVals.push_back(3);
    pulseStart();
    runBlock(40, cycles);
    vectors++;
    if (cycles !== 7) begin miscompares++; $display("[TB] FAIL midrst_cycles: got %0d, expected 7", cycles); end
    vectors++;
    if (q2s(consLog) != "7 1 3 3 5 2 2") begin miscompares++; $display("[TB] FAIL midrst_consumes: got '%s', expected '7 1 3 3 5 2 2'", q2s(consLog)); end
    vectors++;
    if (bus.zeros_left !== 4'd0) begin miscompares++; $display("[TB] FAIL midrst_zeros: got %0d, expected 0", bus.zeros_left); end
  endtask

  // Scenario sequence.
  initial begin
    reset_n             = 1'b0;
    bus.start           = 1'b0;
    bus.max_num_coeff   = 5'd16;
    bus.bits_ready      = 1'b0;
    bus.coeff_token_len = 5'd0;
    bus.total_coeff     = 5'd0;
    bus.trailing_ones   = 2'd0;
    bus.level_len       = 5'd0;
    bus.total_zeros     = 4'd0;
    bus.total_zeros_len = 4'd0;
    bus.run_before      = 4'd0;
    bus.run_before_len  = 4'd0;
    test_reset();
    test_empty_block();
    test_full_path();
    test_max_coeffs();
    test_single_coeff();
    test_run_exit_by_count();
    test_stall();
    test_run_error();
    test_busy_start_ignored();
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
